// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline.
// Covers load-use stalls, branch/jump redirects and the data memory freeze with timeout.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_uses_rt,
  input  logic          ex_memread,
  input  logic [4:0]    ex_rt,
  input  logic          mem_branch,
  input  logic          mem_zero,
  input  logic          mem_memop,
  input  logic          dmem_ready,
  input  logic          wb_jump,
  output logic          pc_write,
  output logic [1:0]    pc_sel,
  output logic          ifid_en,
  output logic          idex_en,
  output logic          exmem_en,
  output logic          memwb_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          memwb_flush,
  output logic          busy,
  output logic          wait_err,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic          err_nx;
  logic          br_tk;
  logic          load_use;
  logic          rel;

  assign br_tk = mem_branch & mem_zero;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) ||
                     (id_uses_rt && (ex_rt == id_rt)));

  assign rel = dmem_ready || (wcnt == WW'(TIMEOUT));

  assign busy = (state == MEM_WAIT);

  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = 2'd0;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_nx    = state;
    wcnt_nx     = wcnt;
    err_nx      = wait_err;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (wb_jump) begin
      // everything younger than WB is squashed, pending memop included
      pc_sel      = 2'd2;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_nx    = RUN;
      wcnt_nx     = '0;
    end else if (br_tk) begin
      pc_sel      = 2'd1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state == RUN) begin
      if (mem_memop && !dmem_ready) begin
        pc_write = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        state_nx = MEM_WAIT;
        wcnt_nx  = WW'(1);
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end else if (rel) begin
      state_nx = RUN;
      wcnt_nx  = '0;
      if (!dmem_ready)
        err_nx = 1'b1;
    end else begin
      pc_write = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      wcnt_nx  = wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= '0;
      wait_err  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      wait_err <= err_nx;
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((pc_sel != 2'd0) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
